// File: rtl/vec_exec_pkg.sv
// Shared opcode/state encodings and helpers for the vector execution unit.
package vec_exec_pkg;

   typedef enum logic [3:0] {
      vop_add_e   = 4'b0000,
      vop_sub_e   = 4'b0001,
      vop_mul_e   = 4'b0010,
      vop_adds_e  = 4'b0100,
      vop_subs_e  = 4'b0101,
      vop_muls_e  = 4'b0110,
      vop_read_e  = 4'b1000,
      vop_write_e = 4'b1001
   } vop_e;

   typedef enum logic [1:0] {
      st_idle_e,
      st_exec_e,
      st_resp_e
   } vec_state_e;

   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic logic is_scalar_op(input logic [3:0] op);
      return (op == vop_adds_e) || (op == vop_subs_e) || (op == vop_muls_e);
   endfunction

   function automatic logic is_arith_op(input logic [3:0] op);
      return (op == vop_add_e) || (op == vop_sub_e) || (op == vop_mul_e) || is_scalar_op(op);
   endfunction

endpackage

// File: rtl/vec_rf.sv
// Vector register file: one full-vector read port, two lane-slice read ports, one full/slice write port.
// Latency: reads combinational, writes land on the clock edge.
// Backpressure: none; the owner sequences all accesses.
module vec_rf
   import vec_exec_pkg::*;
#(
   parameter  int els_p          = 32,
   parameter  int vlen_p         = 8,
   parameter  int vdw_p          = 8,
   parameter  int lanes_p        = 4,
   localparam int addr_width_lp  = safe_clog2(els_p),
   localparam int beat_width_lp  = safe_clog2(vlen_p / lanes_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [addr_width_lp-1:0]    r_addr_i,
   output logic [vlen_p*vdw_p-1:0]     r_data_o,
   input  logic [addr_width_lp-1:0]    a_addr_i,
   input  logic [addr_width_lp-1:0]    b_addr_i,
   input  logic [beat_width_lp-1:0]    beat_i,
   output logic [lanes_p*vdw_p-1:0]    a_data_o,
   output logic [lanes_p*vdw_p-1:0]    b_data_o,
   input  logic                        w_v_i,
   input  logic                        w_full_i,
   input  logic [addr_width_lp-1:0]    w_addr_i,
   input  logic [vlen_p*vdw_p-1:0]     w_full_data_i,
   input  logic [lanes_p*vdw_p-1:0]    w_lane_data_i
);

   localparam int lw_lp = lanes_p * vdw_p;

   logic [vlen_p*vdw_p-1:0] mem [els_p];

   assign r_data_o = mem[r_addr_i];
   assign a_data_o = mem[a_addr_i][beat_i*lw_lp +: lw_lp];
   assign b_data_o = mem[b_addr_i][beat_i*lw_lp +: lw_lp];

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < els_p; i++) mem[i] <= '0;
      end else if (w_v_i) begin
         if (w_full_i) mem[w_addr_i] <= w_full_data_i;
         else          mem[w_addr_i][beat_i*lw_lp +: lw_lp] <= w_lane_data_i;
      end
   end

endmodule

// File: rtl/vec_exec_unit.sv
// Vector execution unit: element-wise add/sub/mult (vv and vs) plus whole-vector read/write.
// Latency: write 1 cycle, read result valid next cycle, arithmetic vlen_p/lanes_p cycles.
// Backpressure: ready_o only in IDLE; read result held in RESP until yumi_i.
module vec_exec_unit
   import vec_exec_pkg::*;
#(
   parameter  int els_p           = 32,
   parameter  int vlen_p          = 8,
   parameter  int vdw_p           = 8,
   parameter  int lanes_p         = 4,
   localparam int v_addr_width_lp = safe_clog2(els_p),
   localparam int beats_lp        = vlen_p / lanes_p,
   localparam int beat_width_lp   = safe_clog2(beats_lp)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [3:0]                  op_i,
   input  logic [v_addr_width_lp-1:0]  vd_addr_i,
   input  logic [v_addr_width_lp-1:0]  vs1_addr_i,
   input  logic [v_addr_width_lp-1:0]  vs2_addr_i,
   input  logic [vdw_p-1:0]            scalar_i,
   input  logic [vlen_p*vdw_p-1:0]     w_data_i,
   input  logic                        v_i,
   output logic                        ready_o,
   output logic [vlen_p*vdw_p-1:0]     r_data_o,
   output logic                        v_o,
   input  logic                        yumi_i,
   output logic                        busy_o,
   output logic                        err_o
);

   if (lanes_p < 1 || lanes_p > vlen_p || (vlen_p % lanes_p) != 0) begin : g_bad_lanes
      $error("vec_exec_unit: lanes_p must divide vlen_p and lie in 1..vlen_p");
   end

   vec_state_e                  state_q;
   logic [beat_width_lp-1:0]    beat_q;
   logic [3:0]                  op_q;
   logic [v_addr_width_lp-1:0]  vd_q, vs1_q, vs2_q;
   logic [vdw_p-1:0]            scalar_q;
   logic [vlen_p*vdw_p-1:0]     r_data_q;
   logic                        err_q;

   logic [vlen_p*vdw_p-1:0]     rf_r_data;
   logic [lanes_p*vdw_p-1:0]    a_lanes, b_lanes, res_lanes;
   logic                        rf_w_v, rf_w_full;
   logic [v_addr_width_lp-1:0]  rf_w_addr;

   assign ready_o  = (state_q == st_idle_e);
   assign busy_o   = (state_q != st_idle_e);
   assign v_o      = (state_q == st_resp_e);
   assign r_data_o = r_data_q;
   assign err_o    = err_q;

   // IDLE uses the port for whole-vector writes; EXEC uses it for lane-slice results.
   assign rf_w_full = (state_q == st_idle_e);
   assign rf_w_v    = (state_q == st_exec_e) || (ready_o && v_i && op_i == vop_write_e);
   assign rf_w_addr = rf_w_full ? vd_addr_i : vd_q;

   vec_rf #(
      .els_p   (els_p),
      .vlen_p  (vlen_p),
      .vdw_p   (vdw_p),
      .lanes_p (lanes_p)
   ) u_rf (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .r_addr_i      (vs1_addr_i),
      .r_data_o      (rf_r_data),
      .a_addr_i      (vs1_q),
      .b_addr_i      (vs2_q),
      .beat_i        (beat_q),
      .a_data_o      (a_lanes),
      .b_data_o      (b_lanes),
      .w_v_i         (rf_w_v),
      .w_full_i      (rf_w_full),
      .w_addr_i      (rf_w_addr),
      .w_full_data_i (w_data_i),
      .w_lane_data_i (res_lanes)
   );

   for (genvar l = 0; l < lanes_p; l++) begin : g_lane
      logic [vdw_p-1:0] a, b, res;
      assign a = a_lanes[l*vdw_p +: vdw_p];
      assign b = is_scalar_op(op_q) ? scalar_q : b_lanes[l*vdw_p +: vdw_p];
      always_comb begin
         res = '0;
         case (op_q)
            vop_add_e, vop_adds_e: res = a + b;
            vop_sub_e, vop_subs_e: res = a - b;
            vop_mul_e, vop_muls_e: res = a * b;
            default:               res = '0;
         endcase
      end
      assign res_lanes[l*vdw_p +: vdw_p] = res;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q  <= st_idle_e;
         beat_q   <= '0;
         op_q     <= '0;
         vd_q     <= '0;
         vs1_q    <= '0;
         vs2_q    <= '0;
         scalar_q <= '0;
         r_data_q <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            st_idle_e: if (v_i) begin
               op_q     <= op_i;
               vd_q     <= vd_addr_i;
               vs1_q    <= vs1_addr_i;
               vs2_q    <= vs2_addr_i;
               scalar_q <= scalar_i;
               beat_q   <= '0;
               if (is_arith_op(op_i))        state_q  <= st_exec_e;
               else if (op_i == vop_read_e) begin
                  state_q  <= st_resp_e;
                  r_data_q <= rf_r_data;
               end else if (op_i != vop_write_e) err_q <= 1'b1;
            end
            st_exec_e: begin
               beat_q <= beat_q + 1'b1;
               if (beat_q == beat_width_lp'(beats_lp - 1)) begin
                  state_q <= st_idle_e;
                  beat_q  <= '0;
               end
            end
            st_resp_e: if (yumi_i) state_q <= st_idle_e;
            default:   state_q <= st_idle_e;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit: directed cases plus random commands against an element-array model.
module tb_vec_exec_unit;

   parameter  int LANES = 4;
   localparam int ELS   = 32;
   localparam int VLEN  = 8;
   localparam int VDW   = 8;
   localparam int BEATS = VLEN / LANES;

   localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010;
   localparam logic [3:0] OP_ADDS = 4'b0100, OP_SUBS = 4'b0101, OP_MULS = 4'b0110;
   localparam logic [3:0] OP_RD = 4'b1000, OP_WR = 4'b1001;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [3:0]      op;
   logic [4:0]      vd, vs1, vs2;
   logic [VDW-1:0]  scalar;
   logic [63:0]     w_data;
   logic            v_in, ready, v_out, yumi, busy, err;
   logic [63:0]     r_data;

   logic [7:0]      model [ELS][VLEN];
   logic [63:0]     last_rd;
   int              n_chk = 0;
   int              n_fail = 0;

   always #5 clk = ~clk;

   vec_exec_unit #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .lanes_p(LANES)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .op_i(op), .vd_addr_i(vd), .vs1_addr_i(vs1),
      .vs2_addr_i(vs2), .scalar_i(scalar), .w_data_i(w_data), .v_i(v_in), .ready_o(ready),
      .r_data_o(r_data), .v_o(v_out), .yumi_i(yumi), .busy_o(busy), .err_o(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mvec(input int r);
      logic [63:0] v;
      for (int k = 0; k < VLEN; k++) v[k*8 +: 8] = model[r][k];
      return v;
   endfunction

   function automatic logic [7:0] alu(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
      int unsigned full;
      case (o[1:0])
         2'd0:    full = a + b;
         2'd1:    full = 256 + a - b;
         default: full = a * b;
      endcase
      return 8'(full % 256);
   endfunction

   // Waits (bounded) for ready, presents one command for exactly one accept edge.
   task automatic issue(input logic [3:0] o, input int d, input int s1, input int s2,
                        input logic [7:0] sc, input logic [63:0] wd);
      int w = 0;
      while (!ready && w < 50) begin @(posedge clk); #1; w++; end
      if (!ready) chk("ready_wait", {63'b0, ready}, 64'd1);
      op = o; vd = 5'(d); vs1 = 5'(s1); vs2 = 5'(s2); scalar = sc; w_data = wd; v_in = 1'b1;
      @(posedge clk); #1;
      v_in = 1'b0;
   endtask

   task automatic wr(input int d, input logic [63:0] wd);
      issue(OP_WR, d, 0, 0, 8'h00, wd);
      for (int k = 0; k < VLEN; k++) model[d][k] = wd[k*8 +: 8];
      chk("write_ready", {63'b0, ready}, 64'd1);
   endtask

   task automatic rd(input int s, input int hold);
      issue(OP_RD, 0, s, 0, 8'h00, 64'h0);
      chk("read_vld", {63'b0, v_out}, 64'd1);
      chk($sformatf("read_v%0d", s), r_data, mvec(s));
      last_rd = r_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("read_hold", {r_data, 1'b0} | {63'b0, v_out}, {last_rd, 1'b0} | 64'd1);
      end
      yumi = 1'b1;
      @(posedge clk); #1;
      yumi = 1'b0;
      chk("read_done_vld", {63'b0, v_out}, 64'd0);
      chk("read_done_rdy", {63'b0, ready}, 64'd1);
   endtask

   task automatic ar(input logic [3:0] o, input int d, input int s1, input int s2, input logic [7:0] sc);
      logic [7:0] res [VLEN];
      int cnt = 0;
      for (int k = 0; k < VLEN; k++)
         res[k] = alu(o, model[s1][k], o[2] ? sc : model[s2][k]);
      issue(o, d, s1, s2, sc, 64'h0);
      while (busy && cnt < 100) begin cnt++; @(posedge clk); #1; end
      chk("exec_cycles", 64'(cnt), 64'(BEATS));
      for (int k = 0; k < VLEN; k++) model[d][k] = res[k];
   endtask

   task automatic bad(input logic [3:0] o);
      issue(o, $urandom_range(0, 7), 1, 2, 8'h00, 64'h0);
      chk("err_pulse", {63'b0, err}, 64'd1);
      chk("err_idle", {63'b0, ready}, 64'd1);
      @(posedge clk); #1;
      chk("err_clear", {63'b0, err}, 64'd0);
   endtask

   always @(negedge clk) if (yumi) chk("yumi_legal", {63'b0, v_out}, 64'd1);

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ill [8] = '{4'd3, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      logic [3:0] ar_ops [6] = '{OP_ADD, OP_SUB, OP_MUL, OP_ADDS, OP_SUBS, OP_MULS};
      int cnt;
      reset_n = 1'b0; op = '0; vd = '0; vs1 = '0; vs2 = '0; scalar = '0; w_data = '0;
      v_in = 1'b0; yumi = 1'b0;
      for (int r = 0; r < ELS; r++) for (int k = 0; k < VLEN; k++) model[r][k] = 8'h00;
      repeat (3) @(posedge clk); #1;
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_vo", {63'b0, v_out}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_err", {63'b0, err}, 64'd0);
      chk("rst_rdata", r_data, 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      rd(0, 5);
      wr(1, 64'h0807060504030201);
      wr(2, 64'hFFFFFFFFFFFFFFFF);
      ar(OP_ADD, 3, 1, 2, 8'h00);
      rd(3, 1);  chk("add_const", last_rd, 64'h0706050403020100);
      ar(OP_SUB, 4, 1, 2, 8'h00);
      rd(4, 0);  chk("sub_const", last_rd, 64'h0908070605040302);
      ar(OP_MULS, 5, 1, 0, 8'h40);
      rd(5, 0);  chk("muls_const", last_rd, 64'h00C0804000C08040);
      ar(OP_ADD, 1, 1, 1, 8'h00);
      rd(1, 0);  chk("alias_const", last_rd, 64'h100E0C0A08060402);

      bad(4'b0011);
      for (int r = 1; r <= 5; r++) rd(r, 0);

      // v_i held through EXEC: the queued write must land only after the add completes
      issue(OP_ADD, 6, 1, 5, 8'h00, 64'h0);
      v_in = 1'b1; op = OP_WR; vd = 5'd7; w_data = 64'hA5A5_5A5A_1234_5678;
      cnt = 0;
      while (busy && cnt < 100) begin
         chk("held_not_ready", {63'b0, ready}, 64'd0);
         cnt++; @(posedge clk); #1;
      end
      chk("held_exec_cycles", 64'(cnt), 64'(BEATS));
      @(posedge clk); #1;
      v_in = 1'b0;
      for (int k = 0; k < VLEN; k++) model[6][k] = 8'(model[1][k] + model[5][k]);
      for (int k = 0; k < VLEN; k++) model[7][k] = w_data[k*8 +: 8];
      chk("held_write_idle", {63'b0, ready}, 64'd1);
      rd(6, 0);
      rd(7, 0);

      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0, 1:    wr($urandom_range(0, 7), {$urandom, $urandom});
            2, 3:    rd($urandom_range(0, 7), $urandom_range(0, 3));
            4:       bad(ill[$urandom_range(0, 7)]);
            default: ar(ar_ops[$urandom_range(0, 5)], $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), 8'($urandom));
         endcase
      end
      for (int r = 0; r < 8; r++) rd(r, 0);

      // reset during beat 1 of a multiply (beat 0 when there is only one beat)
      issue(OP_MUL, 8, 1, 2, 8'h00, 64'h0);
      if (BEATS > 1) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int r = 0; r < ELS; r++) for (int k = 0; k < VLEN; k++) model[r][k] = 8'h00;
      chk("abort_ready", {63'b0, ready}, 64'd1);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_vo", {63'b0, v_out}, 64'd0);
      chk("abort_rdata", r_data, 64'd0);
      @(posedge clk); #1;
      for (int r = 0; r < ELS; r++) rd(r, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
